spi_mem_slave: RTL and testbench
================================

Name: spi_mem_slave

Overview:
Behavioural-but-synthesizable SPI memory slave that sits directly downstream of the SPI master's pin interface (spi_clk / csn / sdo / sdi) in the co-simulation top level.
- Oversamples the SPI pins on the system clock.
- Decodes a small flash-like command set in standard and quad mode.
- Stores bytes in an internal array and returns them on reads, so master transfers can be checked end to end.

Parameters:
MEM_DEPTH, 256, bytes of storage; power of two; address wraps modulo MEM_DEPTH
ADDR_BITS, 24, address bits sent after the command
DUMMY_CYCLES, 8, spi_clk cycles between address and data for quad read (0xEB)
ID_VALUE, 32'h5350_4D31, word returned by read-ID (0x9F), MSB first

Ports:
HCLK  input  1  system clock; at least 4x spi_clk frequency
HRESET  input  1  asynchronous, active-high reset
spi_clk  input  1  SPI clock from master; idle low; mode 0
spi_csn  input  1  chip select from master, active low
spi_mosi  input  4  master sdo0..sdo3
spi_miso  output  4  slave data to master sdi0..sdi3
spi_oe  output  4  per-line drive enable for spi_miso
busy_o  output  1  high while csn is asserted and a command is being processed
last_cmd_o  output  8  opcode of the most recent complete command byte
cmd_err_o  output  1  one-HCLK pulse on an unknown opcode

Behaviour:
- Reset: spi_miso=0, spi_oe=0, busy_o=0, last_cmd_o=0, cmd_err_o=0, FSM=IDLE, all counters=0. Memory array is not reset.
- Synchronization: spi_clk and spi_csn each pass through a 2-flop synchronizer. spi_mosi is sampled in the same HCLK cycle as the synchronized rising-edge pulse.
- Edge timing: sample on synchronized spi_clk rising edge; drive spi_miso on synchronized falling edge. Latency from pin edge to internal action is 3 HCLK.
- States: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, ID_OUT, IGNORE.
- IDLE -> CMD on synchronized csn falling.
- CMD: 8 bits, MSB first, always single-line on mosi[0]. On the 8th bit: update last_cmd_o, then
  - 0x03 read: ADDR single.
  - 0x02 write: ADDR single.
  - 0xEB quad read: ADDR quad.
  - 0x38 quad write: ADDR quad.
  - 0x9F read ID: ID_OUT.
  - any other opcode: pulse cmd_err_o, go to IGNORE.
- ADDR: ADDR_BITS bits in single mode, or ADDR_BITS/4 nibbles on mosi[3:0] (mosi[3] = MSB) in quad mode. Only the low log2(MEM_DEPTH) bits are used. Exit goes to DUMMY for 0xEB with DUMMY_CYCLES>0; otherwise to RD_DATA or WR_DATA.
- DUMMY: count DUMMY_CYCLES rising edges, then RD_DATA.
- RD_DATA, single mode: oe=4'b0010 (sdi1). The byte is driven MSB first. The first bit is driven on the falling edge that ends the last ADDR/DUMMY cycle.
- RD_DATA, quad mode: oe=4'b1111, high nibble first.
- RD_DATA, address increment: after each byte the address increments and wraps from MEM_DEPTH-1 to 0. The next byte is prefetched so there is no bubble.
- WR_DATA: bits are assembled into a byte. The byte is written to mem[addr] on the HCLK after its 8th bit, then addr increments with the same wrap. A partial byte at csn release is discarded.
- ID_OUT: shifts ID_VALUE on sdi1, MSB first. After 32 bits it outputs zeros.
- IGNORE: oe=0 until csn release.
- csn release (synchronized rising) from any state: the FSM returns to IDLE within 1 HCLK; oe=0, busy_o=0, bit counters cleared. A mid-byte release aborts cleanly.
- spi_clk edges while csn is high are ignored.
- HRESET mid-transfer: everything returns to reset values immediately. Memory contents are preserved.

Decomposition:
- Package spi_mem_slave_pkg:
  - opcode constants: OPC_READ=8'h03, OPC_WRITE=8'h02, OPC_QREAD=8'hEB, OPC_QWRITE=8'h38, OPC_RDID=8'h9F
  - state enum typedef
  - io-mode enum (SINGLE, QUAD)
- Sub-module spi_pin_sync: 2-flop synchronizers for spi_clk and spi_csn, plus rise/fall pulse generation for both.

Test Plan:
- Single write then read:
  - Stimulus: 0x02, addr 0x000010, bytes 0xDE 0xAD; release csn; then 0x03, addr 0x000010, read 2 bytes.
  - Required: sdi1 returns 0xDE 0xAD.
- Quad write then quad read:
  - Stimulus: 0x38, addr 0x000020, data 0x12345678; then 0xEB, addr 0x000020, 8 dummy cycles, read 4 bytes.
  - Required: sdi[3:0] nibbles 1,2,…,8; oe=4'hF only during data.
- Wrap-around:
  - Stimulus: write 0xAA, 0xBB at addr 0x0000FF (MEM_DEPTH=256); read from 0x0000FF.
  - Required: returns 0xAA, 0xBB; mem[0]=0xBB.
- Read ID:
  - Stimulus: 0x9F, then 40 spi_clk cycles.
  - Required: sdi1 yields 0x53504D31 followed by 8 zero bits; last_cmd_o=0x9F.
- Unknown opcode and abort:
  - Stimulus: opcode 0x77.
  - Required: one-cycle cmd_err_o, oe stays 0.
  - Stimulus: write 0x02, addr 0x30, 5 bits of data, csn high; then read addr 0x30.
  - Required: old value returned, since the partial byte is discarded.
- Reset mid-read:
  - Stimulus: assert HRESET during RD_DATA.
  - Required: oe=0 and busy_o=0 in the same cycle; a subsequent read of previously written data still returns it.

Source files
------------

// File: rtl/spi_mem_slave_pkg.sv
// Shared opcodes, FSM state and I/O mode types for the SPI memory slave.
package spi_mem_slave_pkg;

  localparam logic [7:0] OPC_READ   = 8'h03;
  localparam logic [7:0] OPC_WRITE  = 8'h02;
  localparam logic [7:0] OPC_QREAD  = 8'hEB;
  localparam logic [7:0] OPC_QWRITE = 8'h38;
  localparam logic [7:0] OPC_RDID   = 8'h9F;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StRdData,
    StWrData,
    StIdOut,
    StIgnore
  } state_e;

  typedef enum logic {
    IoSingle,
    IoQuad
  } io_mode_e;

  // True for opcodes whose data phase is slave-to-master.
  function automatic logic is_read_op(input logic [7:0] opc);
    return (opc == OPC_READ) || (opc == OPC_QREAD);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for spi_clk and spi_csn with single-cycle edge pulses.
module spi_pin_sync (
  input  logic HCLK,
  input  logic HRESET,
  input  logic spi_clk_i,
  input  logic spi_csn_i,
  output logic clk_rise_o,
  output logic clk_fall_o,
  output logic csn_rise_o,
  output logic csn_fall_o
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] clk_q;
  logic [2:0] csn_q;

  // Shift pin levels through the synchronizer chains; csn idles deasserted (high).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      clk_q <= 3'b000;
      csn_q <= 3'b111;
    end else begin
      clk_q <= {clk_q[1:0], spi_clk_i};
      csn_q <= {csn_q[1:0], spi_csn_i};
    end
  end

  assign clk_rise_o =  clk_q[1] & ~clk_q[2];
  assign clk_fall_o = ~clk_q[1] &  clk_q[2];
  assign csn_rise_o =  csn_q[1] & ~csn_q[2];
  assign csn_fall_o = ~csn_q[1] &  csn_q[2];

endmodule

// File: rtl/spi_mem_slave.sv
// Oversampled SPI memory slave: flash-like command decode, single/quad data, byte store.
module spi_mem_slave import spi_mem_slave_pkg::*; #(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [31:0] ID_VALUE     = 32'h5350_4D31
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic [3:0] spi_mosi,
  output logic [3:0] spi_miso,
  output logic [3:0] spi_oe,
  output logic       busy_o,
  output logic [7:0] last_cmd_o,
  output logic       cmd_err_o
);

  localparam int unsigned AW   = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = 16;

  logic clk_rise, clk_fall, csn_rise, csn_fall;

  spi_pin_sync u_pin_sync (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .spi_clk_i  (spi_clk),
    .spi_csn_i  (spi_csn),
    .clk_rise_o (clk_rise),
    .clk_fall_o (clk_fall),
    .csn_rise_o (csn_rise),
    .csn_fall_o (csn_fall)
  );

  state_e                state_q, state_d;
  io_mode_e              mode_q, mode_d;
  logic [CntW-1:0]       cnt_q, cnt_d;       // bits/nibbles/cycles within CMD, ADDR, DUMMY
  logic [2:0]            ph_q, ph_d;         // position within the current data byte
  logic [7:0]            rx_q, rx_d;         // opcode and write-byte assembly
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           tx_q, tx_d;         // outgoing bits, MSB-aligned
  logic [3:0]            miso_q, miso_d;
  logic [3:0]            oe_q, oe_d;
  logic [7:0]            last_cmd_q, last_cmd_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  wr_pend_q, wr_pend_d;

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rd_byte;

  logic [7:0]           rx_shift;
  logic [ADDR_BITS-1:0] addr_shift;
  logic                 addr_last;

  assign rd_byte = mem[addr_q[AW-1:0]];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    last_cmd_d = last_cmd_q;
    cmd_err_d  = 1'b0;
    wr_pend_d  = 1'b0;

    rx_shift   = {rx_q[6:0], spi_mosi[0]};
    addr_shift = (mode_q == IoQuad) ? {addr_q[ADDR_BITS-5:0], spi_mosi}
                                    : {addr_q[ADDR_BITS-2:0], spi_mosi[0]};
    addr_last  = (mode_q == IoQuad) ? (cnt_q == CntW'(ADDR_BITS / 4 - 1))
                                    : (cnt_q == CntW'(ADDR_BITS - 1));

    // The byte committed last cycle has been stored; move to the next location.
    if (wr_pend_q) addr_d = addr_q + ADDR_BITS'(1);

    case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d = StCmd;
          cnt_d   = '0;
        end
      end

      StCmd: begin
        if (clk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(7)) begin
            last_cmd_d = rx_shift;
            cnt_d      = '0;
            case (rx_shift)
              OPC_READ, OPC_WRITE: begin
                state_d = StAddr;
                mode_d  = IoSingle;
              end
              OPC_QREAD, OPC_QWRITE: begin
                state_d = StAddr;
                mode_d  = IoQuad;
              end
              OPC_RDID: begin
                state_d = StIdOut;
                mode_d  = IoSingle;
                tx_d    = ID_VALUE;
              end
              default: begin
                state_d   = StIgnore;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
      end

      StAddr: begin
        if (clk_rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + CntW'(1);
          if (addr_last) begin
            cnt_d = '0;
            ph_d  = '0;
            if (last_cmd_q == OPC_QREAD && DUMMY_CYCLES > 0) begin
              state_d = StDummy;
            end else if (is_read_op(last_cmd_q)) begin
              state_d = StRdData;
            end else begin
              state_d = StWrData;
            end
          end
        end
      end

      StDummy: begin
        if (clk_rise) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = StRdData;
          end
        end
      end

      StRdData: begin
        // Each byte is fetched on the fall that drives its first bit, so bytes abut.
        if (clk_fall) begin
          if (mode_q == IoSingle) begin
            oe_d = 4'b0010;
            if (ph_q == 3'd0) begin
              miso_d = {2'b00, rd_byte[7], 1'b0};
              tx_d   = {rd_byte[6:0], 25'b0};
              addr_d = addr_q + ADDR_BITS'(1);
            end else begin
              miso_d = {2'b00, tx_q[31], 1'b0};
              tx_d   = {tx_q[30:0], 1'b0};
            end
            ph_d = ph_q + 3'd1;
          end else begin
            oe_d = 4'b1111;
            if (ph_q == 3'd0) begin
              miso_d = rd_byte[7:4];
              tx_d   = {rd_byte[3:0], 28'b0};
              addr_d = addr_q + ADDR_BITS'(1);
              ph_d   = 3'd1;
            end else begin
              miso_d = tx_q[31:28];
              ph_d   = 3'd0;
            end
          end
        end
      end

      StWrData: begin
        if (clk_rise) begin
          if (mode_q == IoSingle) begin
            rx_d = rx_shift;
            ph_d = ph_q + 3'd1;
            if (ph_q == 3'd7) wr_pend_d = 1'b1;
          end else begin
            rx_d = {rx_q[3:0], spi_mosi};
            ph_d = (ph_q == 3'd0) ? 3'd1 : 3'd0;
            if (ph_q != 3'd0) wr_pend_d = 1'b1;
          end
        end
      end

      StIdOut: begin
        // Zeros shift in behind the ID word.
        if (clk_fall) begin
          oe_d   = 4'b0010;
          miso_d = {2'b00, tx_q[31], 1'b0};
          tx_d   = {tx_q[30:0], 1'b0};
        end
      end

      StIgnore: ;

      default: state_d = StIdle;
    endcase

    // Deselect wins over everything; a partial write byte is simply dropped.
    if (csn_rise) begin
      state_d = StIdle;
      cnt_d   = '0;
      ph_d    = '0;
      oe_d    = 4'b0000;
      miso_d  = 4'b0000;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= StIdle;
      mode_q     <= IoSingle;
      cnt_q      <= '0;
      ph_q       <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= '0;
      oe_q       <= '0;
      last_cmd_q <= '0;
      cmd_err_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      last_cmd_q <= last_cmd_d;
      cmd_err_q  <= cmd_err_d;
      wr_pend_q  <= wr_pend_d;
    end
  end

  // Byte store; kept out of the reset domain so contents survive HRESET.
  always_ff @(posedge HCLK) begin
    if (wr_pend_q) mem[addr_q[AW-1:0]] <= rx_q;
  end

  assign spi_miso   = miso_q;
  assign spi_oe     = oe_q;
  assign busy_o     = (state_q != StIdle);
  assign last_cmd_o = last_cmd_q;
  assign cmd_err_o  = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench: a mode-0 SPI master model driving spi_mem_slave with hand-computed checks.
module tb_spi_mem_slave;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_csn = 1'b1;
  logic [3:0] spi_mosi = 4'h0;
  logic [3:0] spi_miso;
  logic [3:0] spi_oe;
  logic       busy_o;
  logic [7:0] last_cmd_o;
  logic       cmd_err_o;

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  logic [3:0]  last_mi;
  logic [3:0]  oe_or;
  logic [3:0]  oe_and;
  logic [31:0] v;
  int          err_base;

  spi_mem_slave dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .spi_clk    (spi_clk),
    .spi_csn    (spi_csn),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_oe     (spi_oe),
    .busy_o     (busy_o),
    .last_cmd_o (last_cmd_o),
    .cmd_err_o  (cmd_err_o)
  );

  always #5 HCLK = ~HCLK;

  // Count HCLK cycles with the error pulse high.
  always @(negedge HCLK) if (cmd_err_o === 1'b1) err_pulses <= err_pulses + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge HCLK);
  endtask

  // One spi_clk period: drive mosi, sample miso/oe just before the rising edge.
  task automatic cyc(input logic [3:0] mo);
    spi_mosi = mo;
    half();
    last_mi = spi_miso;
    oe_or   = oe_or | spi_oe;
    oe_and  = oe_and & spi_oe;
    spi_clk = 1'b1;
    half();
    spi_clk = 1'b0;
  endtask

  task automatic select();
    spi_csn = 1'b0;
    half();
  endtask

  task automatic deselect();
    half();
    spi_csn  = 1'b1;
    spi_mosi = 4'h0;
    repeat (6) @(negedge HCLK);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
  endtask

  task automatic tx_nibbles(input logic [7:0] b);
    cyc(b[7:4]);
    cyc(b[3:0]);
  endtask

  task automatic tx_addr(input logic [23:0] a, input bit quad);
    if (quad) for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
    else      for (int i = 23; i >= 0; i--) cyc({3'b000, a[i]});
  endtask

  task automatic rx_single(input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      cyc(4'h0);
      r = {r[30:0], last_mi[1]};
    end
  endtask

  task automatic rx_quad(input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      cyc(4'h0);
      r = {r[27:0], last_mi};
    end
  endtask

  initial begin
    oe_or  = '0;
    oe_and = '1;
    repeat (3) @(negedge HCLK);
    check("rst_miso", spi_miso, 4'h0);
    check("rst_oe", spi_oe, 4'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_last_cmd", last_cmd_o, 8'h00);
    check("rst_cmd_err", cmd_err_o, 1'b0);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);

    // Single write 0xDE 0xAD at 0x10, then read back.
    select();
    tx_byte(8'h02);
    tx_addr(24'h000010, 1'b0);
    check("busy_write", busy_o, 1'b1);
    tx_byte(8'hDE);
    tx_byte(8'hAD);
    deselect();
    check("busy_released", busy_o, 1'b0);
    check("last_cmd_write", last_cmd_o, 8'h02);

    select();
    tx_byte(8'h03);
    tx_addr(24'h000010, 1'b0);
    oe_or = '0; oe_and = '1;
    rx_single(16, v);
    check("single_read", v[15:0], 16'hDEAD);
    check("single_read_oe", {oe_or, oe_and}, 8'h22);
    deselect();
    check("oe_after_release", spi_oe, 4'h0);

    // Quad write 0x12345678 at 0x20, quad read with dummy cycles.
    select();
    tx_byte(8'h38);
    tx_addr(24'h000020, 1'b1);
    tx_nibbles(8'h12);
    tx_nibbles(8'h34);
    tx_nibbles(8'h56);
    tx_nibbles(8'h78);
    deselect();

    select();
    oe_or = '0;
    tx_byte(8'hEB);
    tx_addr(24'h000020, 1'b1);
    for (int i = 0; i < 8; i++) cyc(4'h0);
    check("quad_pre_data_oe", oe_or, 4'h0);
    oe_or = '0; oe_and = '1;
    rx_quad(8, v);
    check("quad_read", v, 32'h1234_5678);
    check("quad_read_oe", {oe_or, oe_and}, 8'hFF);
    check("last_cmd_qread", last_cmd_o, 8'hEB);
    deselect();

    // Wrap-around at the top of memory.
    select();
    tx_byte(8'h02);
    tx_addr(24'h0000FF, 1'b0);
    tx_byte(8'hAA);
    tx_byte(8'hBB);
    deselect();
    select();
    tx_byte(8'h03);
    tx_addr(24'h0000FF, 1'b0);
    rx_single(16, v);
    check("wrap_read", v[15:0], 16'hAABB);
    deselect();
    select();
    tx_byte(8'h03);
    tx_addr(24'h000000, 1'b0);
    rx_single(8, v);
    check("wrap_mem0", v[7:0], 8'hBB);
    deselect();

    // Read ID: 32 ID bits then zeros.
    select();
    tx_byte(8'h9F);
    rx_single(32, v);
    check("read_id", v, 32'h5350_4D31);
    rx_single(8, v);
    check("read_id_tail", v[7:0], 8'h00);
    check("last_cmd_rdid", last_cmd_o, 8'h9F);
    deselect();

    // Unknown opcode: one error pulse, outputs stay disabled.
    check("no_err_on_valid", err_pulses, 0);
    err_base = err_pulses;
    select();
    oe_or = '0;
    tx_byte(8'h77);
    for (int i = 0; i < 4; i++) cyc(4'hF);
    check("unknown_err_pulse", err_pulses - err_base, 1);
    check("unknown_oe", oe_or, 4'h0);
    check("last_cmd_unknown", last_cmd_o, 8'h77);
    deselect();

    // Partial write byte is discarded on release.
    select();
    tx_byte(8'h02);
    tx_addr(24'h000030, 1'b0);
    tx_byte(8'h5A);
    deselect();
    select();
    tx_byte(8'h02);
    tx_addr(24'h000030, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'h1);
    deselect();
    select();
    tx_byte(8'h03);
    tx_addr(24'h000030, 1'b0);
    rx_single(8, v);
    check("abort_keeps_old", v[7:0], 8'h5A);
    deselect();

    // Reset in the middle of a read; memory must survive.
    select();
    tx_byte(8'h03);
    tx_addr(24'h000010, 1'b0);
    rx_single(4, v);
    check("pre_reset_bits", v[3:0], 4'hD);
    check("pre_reset_oe", spi_oe, 4'h2);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check("reset_oe", spi_oe, 4'h0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_last_cmd", last_cmd_o, 8'h00);
    spi_csn = 1'b1;
    repeat (4) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (6) @(negedge HCLK);
    select();
    tx_byte(8'h03);
    tx_addr(24'h000010, 1'b0);
    rx_single(16, v);
    check("read_after_reset", v[15:0], 16'hDEAD);
    deselect();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
